// File: rtl/regfile_sb_pkg.sv
// Shared constants for the write-back register file and its pending-write
// scoreboard. Build option: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
package regfile_sb_pkg;

    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;
    localparam int SbCntWidth   = 2;

    localparam logic [RegAddrWidth-1:0] ZeroRegAddr = '0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_reg_scoreboard.sv
// Per-register pending-writer counters for the register file.
// An issue with a destination increments, a write-back decrements, a flush
// drops every in-flight writer. Over/underflow latches a sticky error that
// only reset clears. Two lookup ports report whether a source is still busy;
// the caller passes in whether the write-back lands on that source this cycle
// so the landing writer can be discounted (bypass builds only).
module regfile_sb_reg_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W = RegAddrWidth,
    parameter int CNT_W  = SbCntWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_hit_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_hit_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              sb_err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] eff_a;
    logic [CNT_W-1:0] eff_b;

    // Next counter values: flush wins over issue, inc+dec cancel, saturate with error.
    always_comb begin : cnt_next_p
        logic inc;
        logic dec;
        err_d = err_q;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            inc = issue_en && (issue_addr == ADDR_W'(i)) && !flush;
            dec = wb_we && (wb_waddr == ADDR_W'(i));
            if (i == 0) begin
                cnt_d[i] = '0;
            end else begin
                if (inc && !dec) begin
                    if (cnt_q[i] == CntMax) err_d = 1'b1;
                    else                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (dec && !inc) begin
                    if (cnt_q[i] == '0) err_d = 1'b1;
                    else                cnt_d[i] = cnt_q[i] - 1'b1;
                end
                if (flush) cnt_d[i] = '0;
            end
        end
    end

    // Counter and sticky error registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Busy lookup, discounting a writer that lands on the source this cycle.
    always_comb begin
        eff_a  = cnt_q[rd_addr_a] - CNT_W'(rd_hit_a);
        eff_b  = cnt_q[rd_addr_b] - CNT_W'(rd_hit_b);
        busy_a = (rd_addr_a != ZeroRegAddr[ADDR_W-1:0]) && (eff_a != '0);
        busy_b = (rd_addr_b != ZeroRegAddr[ADDR_W-1:0]) && (eff_b != '0);
    end

    assign sb_err = err_q;

endmodule : regfile_sb_reg_scoreboard

// File: rtl/regfile_sb.sv
// Write-back register file: 2**ADDR_W x DATA_W integer registers (r0 hardwired
// to zero), two combinational read ports for ID, and a pending-write
// scoreboard that raises stall_req while a used source has an in-flight
// producer. Build option: REGFILE_BYPASS_EN forwards the write-back data to a
// matching read port in the same cycle and stops counting that writer.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = RegWidth,
    parameter int ADDR_W = RegAddrWidth,
    parameter int CNT_W  = SbCntWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              rs1_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic              rs2_en,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    output logic              stall_req,
    output logic              sb_err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] Zero = ZeroRegAddr[ADDR_W-1:0];

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              rs1_hit;
    logic              rs2_hit;
    logic              rs1_busy;
    logic              rs2_busy;

`ifdef REGFILE_BYPASS_EN
    assign rs1_hit = wb_we && (wb_waddr == rs1_addr);
    assign rs2_hit = wb_we && (wb_waddr == rs2_addr);
`else
    assign rs1_hit = 1'b0;
    assign rs2_hit = 1'b0;
`endif

    // Register array next state: commit the write-back unless it targets r0.
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_waddr != Zero)) regs_d[wb_waddr] = wb_wdata;
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    // Read muxes: r0 reads zero, then bypass hit, then stored contents.
    always_comb begin
        if (rs1_addr == Zero) rs1_data = '0;
        else if (rs1_hit)     rs1_data = wb_wdata;
        else                  rs1_data = regs_q[rs1_addr];
        if (rs2_addr == Zero) rs2_data = '0;
        else if (rs2_hit)     rs2_data = wb_wdata;
        else                  rs2_data = regs_q[rs2_addr];
    end

    regfile_sb_reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .flush      (flush),
        .rd_addr_a  (rs1_addr),
        .rd_hit_a   (rs1_hit),
        .rd_addr_b  (rs2_addr),
        .rd_hit_b   (rs2_hit),
        .busy_a     (rs1_busy),
        .busy_b     (rs2_busy),
        .sb_err     (sb_err)
    );

    assign stall_req = (rs1_en && rs1_busy) || (rs2_en && rs2_busy);

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset sweep, a table of per-cycle
// vectors covering bypass, r0, stall, flush and scoreboard saturation, then a
// randomized issue/write/read pass over every register.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        rs1_en;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic        rs2_en;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic        stall_req;
  logic        sb_err;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .rs1_en     (rs1_en),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .rs2_en     (rs2_en),
    .rs2_addr   (rs2_addr),
    .rs2_data   (rs2_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .stall_req  (stall_req),
    .sb_err     (sb_err)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        r1en;
    logic [4:0]  r1a;
    logic        r2en;
    logic [4:0]  r2a;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic        chk;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        est;
    logic        eer;
  } vec_t;

  // scoreboard: {rs1_data, rs2_data, stall_req, sb_err}
  logic [65:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mkv(
    input logic rst_v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic r1en, input logic [4:0] r1a, input logic r2en, input logic [4:0] r2a,
    input logic ie, input logic [4:0] ia, input logic fl,
    input logic [31:0] e1, input logic [31:0] e2, input logic est, input logic eer);
    vec_t v;
    v.rst = rst_v; v.we = we; v.waddr = wa; v.wdata = wd;
    v.r1en = r1en; v.r1a = r1a; v.r2en = r2en; v.r2a = r2a;
    v.ie = ie; v.ia = ia; v.fl = fl; v.chk = 1'b1;
    v.e1 = e1; v.e2 = e2; v.est = est; v.eer = eer;
    return v;
  endfunction

  // driver: apply one cycle of inputs at negedge, check outputs before the next posedge
  task automatic drive(input vec_t v, input string name);
    logic [65:0] exp_v;
    logic [65:0] act_v;
    @(negedge clk);
    rst = v.rst; wb_we = v.we; wb_waddr = v.waddr; wb_wdata = v.wdata;
    rs1_en = v.r1en; rs1_addr = v.r1a; rs2_en = v.r2en; rs2_addr = v.r2a;
    issue_en = v.ie; issue_addr = v.ia; flush = v.fl;
    if (v.chk) exp_q.push_back({v.e1, v.e2, v.est, v.eer});
    #2;
    if (v.chk) begin
      exp_v = exp_q.pop_front();
      act_v = {rs1_data, rs2_data, stall_req, sb_err};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got rs1=%h rs2=%h stall=%b err=%b, want rs1=%h rs2=%h stall=%b err=%b",
                 name, act_v[65:34], act_v[33:2], act_v[1], act_v[0],
                 exp_v[65:34], exp_v[33:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [31:0] rnd;

  initial begin
    // table: rst we wa wdata  r1en r1a r2en r2a  ie ia fl  e_rs1 e_rs2 e_stall e_err
    tbl.push_back(mkv(0,0,0,0,                1,5, 0,0,  1,5, 0, 0,0,0,0));
    tbl.push_back(mkv(0,1,5,32'hDEADBEEF,     1,5, 0,0,  0,0, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 0));
    tbl.push_back(mkv(0,0,0,0,                1,5, 0,0,  0,0, 0, 32'hDEADBEEF,0,0,0));
    tbl.push_back(mkv(0,1,0,32'h1234,         1,0, 1,0,  1,0, 0, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                1,0, 1,0,  0,0, 0, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,7,  1,7, 0, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                1,7, 0,0,  0,0, 0, 0,0,1,0));
    tbl.push_back(mkv(0,0,0,0,                1,7, 0,0,  0,0, 0, 0,0,1,0));
    tbl.push_back(mkv(0,1,7,32'hA5A50007,     1,7, 0,0,  0,0, 0, BYP ? 32'hA5A50007 : 32'h0, 0, !BYP, 0));
    tbl.push_back(mkv(0,0,0,0,                1,7, 0,0,  0,0, 0, 32'hA5A50007,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,9,  1,9, 1, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,9,  0,0, 0, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,10, 1,10,0, 0,0,0,0));
    tbl.push_back(mkv(0,1,10,32'h10,          0,0, 1,10, 1,10,0, 0, BYP ? 32'h10 : 32'h0, !BYP, 0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,10, 1,13,0, 0,32'h10,1,0));
    tbl.push_back(mkv(0,1,10,32'h11,          0,0, 1,10, 0,0, 0, 0, BYP ? 32'h11 : 32'h10, !BYP, 0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 1,10, 0,0, 0, 0,32'h11,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,0, 0,0,  1,12,0, 0,0,0,0));
    tbl.push_back(mkv(0,0,0,0,                0,12,0,12, 0,0, 0, 0,0,0,0));
    tbl.push_back(mkv(0,1,13,32'h1313,        0,13,0,0,  0,0, 1, BYP ? 32'h1313 : 32'h0, 0,0,0));
    tbl.push_back(mkv(0,0,0,0,                1,12,1,13, 0,0, 0, 0,32'h1313,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mkv(0,0,0,0,              0,0, 0,0,  1,3, 0, 0,0,0,0));
    tbl.push_back(mkv(0,1,3,32'h30,           1,3, 0,0,  0,0, 0, BYP ? 32'h30 : 32'h0, 0,1,1));
    tbl.push_back(mkv(0,1,3,32'h31,           1,3, 0,0,  0,0, 0, BYP ? 32'h31 : 32'h30, 0,1,1));
    tbl.push_back(mkv(0,0,0,0,                1,3, 0,0,  0,0, 0, 32'h31,0,1,1));
    tbl.push_back(mkv(0,0,0,0,                1,3, 0,0,  0,0, 1, 32'h31,0,1,1));
    tbl.push_back(mkv(0,0,0,0,                1,3, 0,0,  0,0, 0, 32'h31,0,0,1));
    tbl.push_back(mkv(1,1,5,32'hFFFF0000,     0,0, 0,0,  1,5, 0, 0,0,0,1));
    tbl.push_back(mkv(0,0,0,0,                1,5, 1,3,  0,0, 0, 0,0,0,0));
    tbl.push_back(mkv(0,1,20,32'h20,          0,20,0,0,  0,0, 0, BYP ? 32'h20 : 32'h0, 0,0,0));
    tbl.push_back(mkv(0,0,0,0,                1,20,0,0,  0,0, 0, 32'h20,0,0,1));

    // reset phase
    rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    rs1_en = 1'b0; rs1_addr = '0; rs2_en = 1'b0; rs2_addr = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    repeat (3) @(negedge clk);

    // reset state: every register reads 0, no stall, no error
    for (int i = 0; i < 32; i++) begin
      v = mkv(0,0,0,0, 1,5'(i), 1,5'(31 - i), 0,0, 0, 0,0,0,0);
      drive(v, $sformatf("reset_r%0d", i));
    end

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("vec%0d", i));

    // randomized issue -> write -> read per register; error flag is still set
    for (int i = 1; i < 32; i++) begin
      rnd = $urandom_range(32'hFFFF_FFFE, 1);
      v = mkv(0,0,0,0, 0,0, 0,0, 1,5'(i), 0, 0,0,0,0);
      v.chk = 1'b0;
      drive(v, "rand_issue");
      v = mkv(0,1,5'(i),rnd, 0,0, 0,0, 0,0, 0, 0,0,0,0);
      v.chk = 1'b0;
      drive(v, "rand_write");
      v = mkv(0,0,0,0, 1,5'(i), 1,5'(i), 0,0, 0, rnd,rnd,0,1);
      drive(v, $sformatf("rand_read_r%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no summary, want summary");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_sb
